// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-family logic models: 74259 mode encoding and decode helper.
package ttl_pkg;

  localparam int TTL74259_NLATCH = 8;

  // Mode is indexed by the sampled {CLR_n, G_n} pair.
  typedef enum logic [1:0] {
    DEMUX      = 2'b00,
    CLEAR      = 2'b01,
    ADDR_LATCH = 2'b10,
    MEMORY     = 2'b11
  } ttl74259_mode_e;

  function automatic logic [TTL74259_NLATCH-1:0] ttl74259_onehot(input logic [2:0] sel);
    logic [TTL74259_NLATCH-1:0] v;
    v = {{(TTL74259_NLATCH-1){1'b0}}, 1'b1} << sel;
    return v;
  endfunction

endpackage

// File: rtl/ttl_74259_chk.sv
// Simulation checker for ttl_74259: select lines must be known whenever the
// latch is enabled.
module ttl_74259_chk (
  input logic       CLK,
  input logic       RST,
  input logic       G_n,
  input logic [2:0] S
);

  // Flag an unknown select on any enabled edge.
  always_ff @(posedge CLK) begin
    if (!RST && (G_n === 1'b0)) begin
      assert (!$isunknown(S))
        else $error("ttl_74259: X/Z on S while G_n=0");
    end
  end

endmodule

// File: rtl/ttl_sync2.sv
// Width-parameterised two-flop synchroniser with asynchronous active-high reset
// and a reset value parameter; shared by TTL models that accept async inputs.
module ttl_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ttl_74259.sv
// Clocked model of the TTL 74259 8-bit addressable latch.
// Define TTL_74259_SYNC_EN to pass all inputs through a 2-flop synchroniser (latency 3).
module ttl_74259
  import ttl_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       G_n,
  input  logic       CLR_n,
  input  logic [2:0] S,
  input  logic       D,
  output logic [7:0] Q
);

  logic           g_n_s;
  logic           clr_n_s;
  logic [2:0]     s_s;
  logic           d_s;
  ttl74259_mode_e mode_s;
  logic [7:0]     sel_s;
  logic [7:0]     q_nxt_s;
  logic [7:0]     q_r;

`ifdef TTL_74259_SYNC_EN
  // Reset value puts the synchronised controls in MEMORY mode.
  ttl_sync2 #(
    .WIDTH     (6),
    .RESET_VAL (6'b110000)
  ) u_sync (
    .clk (CLK),
    .rst (RST),
    .d   ({G_n, CLR_n, S, D}),
    .q   ({g_n_s, clr_n_s, s_s, d_s})
  );
`else
  assign g_n_s   = G_n;
  assign clr_n_s = CLR_n;
  assign s_s     = S;
  assign d_s     = D;
`endif

  assign mode_s = ttl74259_mode_e'({clr_n_s, g_n_s});
  assign sel_s  = ttl74259_onehot(s_s);

  // Next-state decode of the latch bank from the current mode.
  always_comb begin
    q_nxt_s = q_r;
    case (mode_s)
      ADDR_LATCH: q_nxt_s = (q_r & ~sel_s) | (d_s ? sel_s : 8'h00);
      MEMORY:     q_nxt_s = q_r;
      DEMUX:      q_nxt_s = d_s ? sel_s : 8'h00;
      CLEAR:      q_nxt_s = 8'h00;
      default:    q_nxt_s = q_r;
    endcase
  end

  // Latch bank register; reset wins over any coincident edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= q_nxt_s;
    end
  end

  assign Q = q_r;

  ttl_74259_chk u_chk (
    .CLK (CLK),
    .RST (RST),
    .G_n (g_n_s),
    .S   (s_s)
  );

endmodule

// File: tb/tb_ttl_74259.sv
// Directed self-checking bench for ttl_74259 (honours TTL_74259_SYNC_EN latency).
module tb_ttl_74259;

`ifdef TTL_74259_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       CLK;
  logic       RST;
  logic       G_n;
  logic       CLR_n;
  logic [2:0] S;
  logic       D;
  logic [7:0] Q;

  int checks;
  int errors;

  ttl_74259 #(.RESET_VAL(8'h00)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .G_n   (G_n),
    .CLR_n (CLR_n),
    .S     (S),
    .D     (D),
    .Q     (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (Q === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, Q, exp);
      end
  endtask

  // Called at a negedge: drive inputs, let LAT rising edges pass, return at a negedge.
  task automatic apply(input logic clr, input logic g, input logic [2:0] s, input logic d);
    CLR_n = clr;
    G_n   = g;
    S     = s;
    D     = d;
    repeat (LAT) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    CLR_n = 1'b1;
    G_n = 1'b1;
    S = 3'd0;
    D = 1'b0;
    #1;
    chk("reset_initial", 8'h00);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Build Q=A5 (bits 0,2,5,7) in address-latch mode.
    apply(1'b1, 1'b0, 3'd0, 1'b1);
    apply(1'b1, 1'b0, 3'd2, 1'b1);
    apply(1'b1, 1'b0, 3'd5, 1'b1);
    apply(1'b1, 1'b0, 3'd7, 1'b1);
    chk("build_a5", 8'hA5);

    // Mid-run asynchronous reset takes effect before any clock edge.
    #2 RST = 1'b1;
    #1 chk("reset_async", 8'h00);
    @(negedge CLK);
    CLR_n = 1'b1; G_n = 1'b0; S = 3'd1; D = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_held", 8'h00);
    CLR_n = 1'b1; G_n = 1'b1;
    RST = 1'b0;
    apply(1'b1, 1'b1, 3'd1, 1'b1);
    apply(1'b1, 1'b1, 3'd4, 1'b0);
    chk("reset_release_memory", 8'h00);

    // Address-latch writes, including clearing one earlier-written bit.
    apply(1'b1, 1'b0, 3'd0, 1'b1);
    chk("addr_s0", 8'h01);
    apply(1'b1, 1'b0, 3'd3, 1'b1);
    chk("addr_s3", 8'h09);
    apply(1'b1, 1'b0, 3'd7, 1'b1);
    chk("addr_s7", 8'h89);
    apply(1'b1, 1'b0, 3'd3, 1'b0);
    chk("addr_s3_d0", 8'h81);

    // Memory mode ignores S/D.
    for (int i = 0; i < 20; i++) begin
      CLR_n = 1'b1;
      G_n = 1'b1;
      S = 3'($urandom_range(0, 7));
      D = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    repeat (LAT) @(negedge CLK);
    chk("memory_hold", 8'h81);

    // Fill all latches, then demultiplex.
    for (int i = 0; i < 8; i++) apply(1'b1, 1'b0, 3'(i), 1'b1);
    chk("fill_ff", 8'hFF);
    apply(1'b0, 1'b0, 3'd5, 1'b1);
    chk("demux_s5_d1", 8'h20);
    apply(1'b0, 1'b0, 3'd5, 1'b0);
    chk("demux_s5_d0", 8'h00);
    apply(1'b0, 1'b0, 3'd7, 1'b1);
    chk("demux_s7_d1", 8'h80);
    apply(1'b0, 1'b0, 3'd0, 1'b1);
    chk("demux_s0_d1", 8'h01);

    // Clear dominates S/D.
    apply(1'b0, 1'b1, 3'd0, 1'b0);
    apply(1'b1, 1'b0, 3'd1, 1'b1);
    apply(1'b1, 1'b0, 3'd3, 1'b1);
    apply(1'b1, 1'b0, 3'd4, 1'b1);
    apply(1'b1, 1'b0, 3'd6, 1'b1);
    chk("build_5a", 8'h5A);
    apply(1'b0, 1'b1, 3'd6, 1'b1);
    chk("clear", 8'h00);

    // Reset released around a clock edge in address-latch mode.
    apply(1'b1, 1'b0, 3'd6, 1'b1);
    chk("pre_race", 8'h40);
    RST = 1'b1;
    CLR_n = 1'b1; G_n = 1'b0; S = 3'd2; D = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("race_edge", 8'h00);
    repeat (LAT) @(posedge CLK);
    @(negedge CLK);
    chk("race_next", 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
